// File: rtl/heliosmart_pkg.sv
// heliosmart_pkg: shared types and helpers for the front-panel blocks
// (keypad scanner state encoding, key code width, microsecond-to-cycle conversion).
package heliosmart_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_e;

  localparam int KEY_W = 4;

  function automatic int us_to_cycles(input int freq_mhz, input int us);
    return freq_mhz * us;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-code output towards the led stage.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  import heliosmart_pkg::*;

  logic [3:0]       row;
  logic [3:0]       col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held
  );

endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for the asynchronous keypad rows; resets to all-ones
// so an idle (pulled-up) keypad is seen straight out of reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             _rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] row_p0;

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      row_p0 <= '1;
      q      <= '1;
    end else begin
      row_p0 <= d;
      q      <= row_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, single-key debounce, registered key code/valid/held.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scanner
  import heliosmart_pkg::*;
#(
  parameter int FREQ_MHZ        = 50,
  parameter int SCAN_US         = 1000,
  parameter int DEBOUNCE_US     = 20000,
  parameter int REPEAT_DELAY_US = 500000,
  parameter int REPEAT_RATE_US  = 100000
) (
  input logic              sys_clk,
  input logic              _rst,
  keypad_scanner_if.master bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  localparam int SCAN_CYC = us_to_cycles(FREQ_MHZ, SCAN_US);
  localparam int DB_CYC   = us_to_cycles(FREQ_MHZ, DEBOUNCE_US);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_DLY_CYC  = us_to_cycles(FREQ_MHZ, REPEAT_DELAY_US);
  localparam int REP_RATE_CYC = us_to_cycles(FREQ_MHZ, REPEAT_RATE_US);
  localparam int MAX_CYC      = max2(max2(SCAN_CYC, DB_CYC), max2(REP_DLY_CYC, REP_RATE_CYC));
`else
  localparam int MAX_CYC      = max2(SCAN_CYC, DB_CYC);
`endif
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  if (FREQ_MHZ < 1 || SCAN_US < 1 || DEBOUNCE_US < 1 ||
      REPEAT_DELAY_US < 1 || REPEAT_RATE_US < 1) begin : g_bad_param
    $error("keypad_scanner: timing parameters must be positive");
  end

  scan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [3:0]       pat, pat_nxt;
  logic [3:0]       col_drv, col_drv_nxt;
  logic [KEY_W-1:0] code_q, code_nxt;
  logic             valid_q, valid_nxt;
  logic             held_q, held_nxt;
  logic [3:0]       row_s;
  logic             dwell_done, db_done, rows_idle;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic             rep_armed, rep_armed_nxt;
`endif

  sync2 #(.WIDTH(4)) u_sync (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .d       (bus.row),
    .q       (row_s)
  );

  assign dwell_done = (cnt == CNT_W'(SCAN_CYC - 1));
  assign db_done    = (cnt == CNT_W'(DB_CYC - 1));
  assign rows_idle  = (row_s == 4'hF);

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:       if (dwell_done && !rows_idle) state_nxt = DEBOUNCE;
      DEBOUNCE:   if (row_s != pat)             state_nxt = SCAN;
                  else if (db_done)             state_nxt = PRESSED;
      PRESSED:    if (rows_idle)                state_nxt = RELEASE_DB;
      RELEASE_DB: if (!rows_idle)               state_nxt = PRESSED;
                  else if (db_done)             state_nxt = SCAN;
      default:                                  state_nxt = SCAN;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt + 1'b1;
    col_idx_nxt = col_idx;
    row_idx_nxt = row_idx;
    pat_nxt     = pat;
    code_nxt    = code_q;
    valid_nxt   = 1'b0;
    held_nxt    = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_armed_nxt = (state == PRESSED) ? rep_armed : 1'b0;
`endif
    case (state)
      SCAN: begin
        if (dwell_done) begin
          cnt_nxt = '0;
          if (!rows_idle) begin
            pat_nxt     = row_s;
            row_idx_nxt = lowest_low(row_s);
          end else begin
            col_idx_nxt = col_idx + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s != pat) begin
          cnt_nxt = '0;
        end else if (db_done) begin
          cnt_nxt   = '0;
          code_nxt  = {row_idx, col_idx};
          valid_nxt = 1'b1;
          held_nxt  = 1'b1;
        end
      end
      PRESSED: begin
        if (rows_idle) begin
          cnt_nxt = '0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          // First repeat waits the long delay, later ones use the shorter rate.
          if (!rep_armed && cnt == CNT_W'(REP_DLY_CYC - 1)) begin
            cnt_nxt       = '0;
            valid_nxt     = 1'b1;
            rep_armed_nxt = 1'b1;
          end else if (rep_armed && cnt == CNT_W'(REP_RATE_CYC - 1)) begin
            cnt_nxt   = '0;
            valid_nxt = 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      RELEASE_DB: begin
        if (!rows_idle) begin
          cnt_nxt = '0;
        end else if (db_done) begin
          cnt_nxt     = '0;
          held_nxt    = 1'b0;
          col_idx_nxt = col_idx + 1'b1;
        end
      end
      default: cnt_nxt = '0;
    endcase
    col_drv_nxt = ~(4'b0001 << col_idx_nxt);
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      cnt       <= '0;
      col_idx   <= 2'd0;
      col_drv   <= 4'b1110;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_armed <= 1'b0;
`endif
    end else begin
      cnt       <= cnt_nxt;
      col_idx   <= col_idx_nxt;
      col_drv   <= col_drv_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
      held_q    <= held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_armed <= rep_armed_nxt;
`endif
    end
  end

  // Captured row pattern and winning row are only read after being loaded in SCAN.
  always_ff @(posedge sys_clk) begin
    pat     <= pat_nxt;
    row_idx <= row_idx_nxt;
  end

  assign bus.col       = col_drv;
  assign bus.key_code  = code_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

4x4 matrix-keypad scanner with per-key debounce for the lux/PWM front panel. It drives the keypad columns, samples the rows, and debounces one key at a time. It then publishes a 4-bit key code: the `numteclado` value consumed by the `led` PWM stage, alongside `selectmode`. It sits directly upstream of `led` in the top level, in parallel with the BH1750 reader, on the same 50 MHz clock.

## Interface
- `FREQ_MHZ`, 50, system clock frequency in MHz.
- `SCAN_US`, 1000, column dwell time in µs.
- `DEBOUNCE_US`, 20000, time a key must be stable to press or release.
- `REPEAT_DELAY_US`, 500000, hold time before the first auto-repeat. Used only with the macro.
- `REPEAT_RATE_US`, 100000, auto-repeat period. Used only with the macro.
- `sys_clk`  in  1  system clock, rising edge.
- `_rst`  in  1  reset, asynchronous, active-low.
- `row`  in  4  keypad rows, pulled up externally, low = contact. Asynchronous to `sys_clk`.
- `col`  out  4  column drive, one bit low at a time, others high.
- `key_code`  out  4  last accepted key, code = 4*row_idx + col_idx. Feeds `numteclado`.
- `key_valid`  out  1  one-cycle pulse, same cycle `key_code` updates.
- `key_held`  out  1  high from the accept cycle until release debounce completes.

## Operation
- `row` passes through a 2-FF synchronizer; all logic uses the synchronized `row_s`.
- Derived cycle counts: `SCAN_CYC = FREQ_MHZ*SCAN_US`, `DB_CYC = FREQ_MHZ*DEBOUNCE_US`. The counter is wide enough for the largest count; no wrap inside a state.
- **SCAN**
  - Drive column `c`; dwell counter runs.
  - At end of dwell, if `row_s != 4'hF`: capture `c` and the lowest low row index `r`, then go to DEBOUNCE.
  - Otherwise advance `c` modulo 4 (3 wraps to 0), clear the counter, and stay in SCAN.
- **DEBOUNCE**
  - Column frozen.
  - Each cycle `row_s` must equal the captured pattern. Any mismatch, including release or an added key, returns to SCAN on the same column with the counter cleared.
  - When the counter reaches `DB_CYC-1`: update `key_code = {r,c}`, pulse `key_valid`, set `key_held`, go to PRESSED.
- **PRESSED**
  - Column frozen.
  - On `row_s == 4'hF`, go to RELEASE_DB with the counter cleared.
  - Changes among pressed keys are ignored; there is no rollover.
- **RELEASE_DB**
  - Requires `row_s == 4'hF` for `DB_CYC` consecutive cycles, then clears `key_held`, advances the column, and returns to SCAN.
  - Any low row returns to PRESSED with no new `key_valid`.
- **Multiple keys:** only the column found first is considered. Within that column the lowest row index wins.
- **Reset:** state = SCAN, `col = 4'b1110`, `key_code = 0`, `key_valid = 0`, `key_held = 0`, counters and synchronizer cleared to idle (rows read as 1). Reset asserted mid-DEBOUNCE or mid-PRESSED aborts with no pulse.

## Timing
- Row-to-logic latency is 2 cycles (synchronizer).
- Press latency: `key_valid` fires `DB_CYC` cycles after the first cycle `row_s` shows the key in DEBOUNCE. Worst case adds `4*SCAN_CYC` of scan phase.
- `key_valid` is exactly 1 cycle wide. `key_code` is stable between pulses.
- `col` changes only on SCAN dwell expiry or on exit from RELEASE_DB.
- Outputs are registered; no combinational path from `row` to any output.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter pulses `key_valid` (same `key_code`) after `REPEAT_DELAY_US` of continuous hold.
  - Further pulses follow every `REPEAT_RATE_US`.
  - The counter is cleared on entry to PRESSED and held cleared in RELEASE_DB. A return from RELEASE_DB to PRESSED restarts the delay.
- Undefined: exactly one `key_valid` per press. The repeat parameters are ignored and no repeat logic is synthesized.

## Structure
- Shared package `heliosmart_pkg`: the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE_DB), `KEY_W = 4`, and the `us_to_cycles` constant function.
- One natural sub-module, `sync2`: a 2-FF synchronizer, 4 bits wide, with the same `sys_clk`/`_rst`, reset value 1.

## Test plan
Bench uses `FREQ_MHZ=1`, `SCAN_US=4`, `DEBOUNCE_US=20`, `REPEAT_DELAY_US=60`, `REPEAT_RATE_US=30`.
- **Reset:** hold `_rst` low → `col=1110`, `key_code=0`, `key_valid=0`, `key_held=0`. Release with no keys → `col` rotates 1110→1101→1011→0111→1110, 4 cycles each.
- **Single press:** close row 2 / col 1 for 100 cycles → exactly one `key_valid` with `key_code=9`. `key_held` is high until 20 cycles after release.
- **Bounce:** toggle row 0 / col 3 every 5 cycles for 60 cycles, then open → no `key_valid`; state returns to SCAN.
- **Release glitch and two keys:** release for 10 cycles, then re-close → no second pulse. Separately, close rows 1 and 3 on col 0 together → `key_code=4` only.
- **Reset mid-debounce:** assert `_rst` 10 cycles into DEBOUNCE → no pulse and all outputs at reset values.
- **Auto-repeat (macro on):** hold row 3 / col 3 for 150 cycles → `key_valid` pulses with `key_code=15` at accept, +60, +90, +120. With the macro off, only the accept pulse.
